alu_with_mult: RTL and testbench

- 32-bit ALU with eight operations selected by a 3-bit opcode.
- Seven operations are single-cycle combinational.
- Multiply is a sequential shift-and-add unit taking 33 clock cycles.
- Serves as the execution unit of the datapath; result is read by downstream logic after the multiply latency elapses.

---
 rtl/alu_pkg.sv | 13 +
 rtl/seq_multiplier.sv | 49 ++++
 rtl/alu_with_mult.sv | 36 +++
 tb/tb_alu_with_mult.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, default width and multiplier FSM states shared by the ALU.
package alu_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MULT = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_NOR  = 3'b111;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, one load edge then W iterations; low W bits of a*b.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         done
);
    localparam int CW = $clog2(W) + 1;
    mult_state_t state, next_state;
    logic [W-1:0] mcand, mplier;
    logic [CW-1:0] count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end
    // Dropping start in BUSY or DONE returns to IDLE so a fresh multiply needs start to toggle.
    always_comb begin
        next_state = IDLE;
        if (state == IDLE)      next_state = start ? BUSY : IDLE;
        else if (state == BUSY) next_state = !start ? IDLE : (count == CW'(W - 1)) ? DONE : BUSY;
        else if (state == DONE) next_state = start ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else if (state == IDLE && start) begin
            product <= '0;
            mcand   <= a;
            mplier  <= b;
            count   <= '0;
        end else if (state == BUSY && start) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end
    assign done = (state == DONE);
endmodule

// File: rtl/alu_with_mult.sv
// alu_with_mult: combinational ALU ops plus a sequential multiplier selected by opcode 010.
module alu_with_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] product;
    logic lt;
    seq_multiplier #(.W(WIDTH)) u_mult (
        .clk(clk),
        .rst(rst),
        .start(aluop == ALU_MULT),
        .a(a),
        .b(b),
        .product(product),
        .done()
    );
    assign lt = $signed(a) < $signed(b);
    always_comb begin
        result = (aluop == ALU_ADD)  ? a + b :
                 (aluop == ALU_SUB)  ? a - b :
                 (aluop == ALU_MULT) ? product :
                 (aluop == ALU_XOR)  ? a ^ b :
                 (aluop == ALU_AND)  ? a & b :
                 (aluop == ALU_OR)   ? a | b :
                 (aluop == ALU_SLT)  ? {{(WIDTH-1){1'b0}}, lt} :
                                       ~(a | b);
    end
endmodule

// File: tb/tb_alu_with_mult.sv
// tb_alu_with_mult: directed scoreboard bench; expectations queued at drive time, popped at check time.
module tb_alu_with_mult;
    import alu_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [2:0]  aluop;
    logic [31:0] result;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail = 0;

    alu_with_mult dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .aluop(aluop),
        .result(result)
    );

    always #2 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: result=%h required=bench completion", result);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check();
        logic [31:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (result === e) else begin
            n_fail++;
            $error("FAIL %s: result=%h expected=%h", t, result, e);
        end
    endtask

    task automatic comb(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input string tag);
        a = x;
        b = y;
        aluop = op;
        push(tag, e);
        #1;
        check();
    endtask

    // Leaves 010 for one edge so the FSM is IDLE, then starts and waits the full latency.
    task automatic mult(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e,
                        input string tag);
        aluop = ALU_ADD;
        tick(1);
        a = x;
        b = y;
        aluop = ALU_MULT;
        push(tag, e);
        tick(33);
        check();
    endtask

    initial begin
        rst = 1'b0;
        a = 32'd12;
        b = 32'd8;
        aluop = ALU_MULT;
        tick(2);
        push("reset_mult_zero", 32'd0);
        check();
        comb(ALU_ADD, 32'd12, 32'd8, 32'd20, "add_12_8");
        comb(ALU_SUB, 32'd12, 32'd8, 32'd4, "sub_12_8");
        comb(ALU_XOR, 32'd12, 32'd8, 32'd4, "xor_12_8");
        comb(ALU_AND, 32'd12, 32'd8, 32'd8, "and_12_8");
        comb(ALU_OR,  32'd12, 32'd8, 32'd12, "or_12_8");
        comb(ALU_SLT, 32'd12, 32'd8, 32'd0, "slt_12_8");
        comb(ALU_NOR, 32'd12, 32'd8, 32'hFFFF_FFF3, "nor_12_8");
        @(posedge clk);
        #1;
        rst = 1'b1;
        mult(32'd12, 32'd8, 32'd96, "mult_12_8");
        push("mult_12_8_hold", 32'd96);
        tick(58);
        check();
        a = 32'd1;
        push("mult_hold_operand_change", 32'd96);
        tick(2);
        check();
        comb(ALU_SLT, 32'hFFFF_FFFB, 32'd3, 32'd1, "slt_neg5_3");
        mult(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFF1, "mult_neg5_3");
        comb(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_wrap");
        comb(ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, "sub_wrap");
        comb(ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, "slt_min_max");
        comb(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, "slt_max_min");
        // Top multiplier bit only contributes on the last iteration, exposing the latency.
        aluop = ALU_ADD;
        tick(1);
        a = 32'd3;
        b = 32'h8000_0001;
        aluop = ALU_MULT;
        push("mult_latency_edge32", 32'd3);
        push("mult_latency_edge33", 32'h8000_0003);
        tick(32);
        check();
        tick(1);
        check();
        aluop = ALU_ADD;
        tick(1);
        a = 32'd7;
        b = 32'd9;
        aluop = ALU_MULT;
        tick(9);
        rst = 1'b0;
        push("reset_mid_mult", 32'd0);
        #1;
        check();
        tick(2);
        rst = 1'b1;
        push("mult_after_reset", 32'd63);
        tick(33);
        check();
        aluop = ALU_ADD;
        tick(1);
        a = 32'd3;
        b = 32'd4;
        aluop = ALU_MULT;
        tick(4);
        a = 32'd100;
        push("mult_operand_change", 32'd12);
        tick(29);
        check();
        aluop = ALU_ADD;
        tick(1);
        a = 32'd3;
        b = 32'd4;
        aluop = ALU_MULT;
        tick(9);
        comb(ALU_ADD, 32'd3, 32'd4, 32'd7, "abort_add");
        tick(1);
        a = 32'd5;
        b = 32'd6;
        aluop = ALU_MULT;
        push("restart_cleared", 32'd0);
        push("restart_mult_5_6", 32'd30);
        tick(1);
        check();
        tick(32);
        check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
